// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Brief    : Run/halt/step sequencer and instruction-memory loader for the
//            4-bit CPU core, with PC breakpoint and saturating cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [7:0]        cmd_data,
    input  logic [ADDR_W-1:0] cpu_pc,
    input  logic              cpu_halted,
    output logic              cpu_en,
    output logic              cpu_rst,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic [1:0]        state,
    output logic              bp_hit,
    output logic [15:0]       cycle_cnt
);

    localparam logic [1:0] c_ST_HALT   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_STEP   = 2'd2;
    localparam logic [1:0] c_ST_CPURST = 2'd3;

    localparam logic [2:0] c_OP_SET_ADDR  = 3'd1;
    localparam logic [2:0] c_OP_WRITE     = 3'd2;
    localparam logic [2:0] c_OP_RUN       = 3'd3;
    localparam logic [2:0] c_OP_STEP      = 3'd4;
    localparam logic [2:0] c_OP_HALT      = 3'd5;
    localparam logic [2:0] c_OP_SET_BP    = 3'd6;
    localparam logic [2:0] c_OP_RESET_CPU = 3'd7;

    localparam int              c_RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_RC_W-1:0] c_RST_LAST = c_RC_W'(RST_CYCLES - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_cpu_rst;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [7:0]        r_imem_wdata;
    logic              r_bp_hit;
    logic [15:0]       r_cycle_cnt;
    logic              r_bp_en;
    logic [ADDR_W-1:0] r_bp_addr;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_skip;
    logic [c_RC_W-1:0] r_rst_cnt;

    logic              w_cmd_ready;
    logic              w_accept;
    logic              w_cmd_stop;
    logic              w_bp_match;
    logic              w_cpu_en;

    assign w_cmd_ready = (r_state == c_ST_HALT) || (r_state == c_ST_RUN);
    assign w_accept    = cmd_valid && w_cmd_ready;
    assign w_cmd_stop  = w_accept && ((cmd_op == c_OP_HALT) || (cmd_op == c_OP_RESET_CPU));
    // The skip flag lets a RUN issued while parked on the breakpoint PC get past it.
    assign w_bp_match  = r_bp_en && (cpu_pc == r_bp_addr) && !r_skip;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_CPURST;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; core stop conditions outrank host commands in RUN
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_HALT: begin
                if (w_accept) begin
                    case (cmd_op)
                        c_OP_RUN:       w_next_state = c_ST_RUN;
                        c_OP_STEP:      w_next_state = c_ST_STEP;
                        c_OP_RESET_CPU: w_next_state = c_ST_CPURST;
                        default:        w_next_state = c_ST_HALT;
                    endcase
                end
            end
            c_ST_RUN: begin
                if (cpu_halted || w_bp_match) begin
                    w_next_state = c_ST_HALT;
                end else if (w_accept && (cmd_op == c_OP_HALT)) begin
                    w_next_state = c_ST_HALT;
                end else if (w_accept && (cmd_op == c_OP_RESET_CPU)) begin
                    w_next_state = c_ST_CPURST;
                end
            end
            c_ST_STEP: begin
                w_next_state = c_ST_HALT;
            end
            default: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_next_state = c_ST_HALT;
                end
            end
        endcase
    end

    // Output logic
    always_comb begin
        w_cpu_en = 1'b0;
        case (r_state)
            c_ST_RUN:  w_cpu_en = !cpu_halted && !w_bp_match && !w_cmd_stop;
            c_ST_STEP: w_cpu_en = !cpu_halted;
            default:   w_cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_rst    <= 1'b1;
            r_rst_cnt    <= '0;
            r_cycle_cnt  <= 16'd0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 8'd0;
            r_ptr        <= '0;
            r_bp_en      <= 1'b0;
            r_bp_addr    <= '0;
            r_bp_hit     <= 1'b0;
            r_skip       <= 1'b0;
        end else begin
            r_cpu_rst <= (w_next_state == c_ST_CPURST);
            r_imem_we <= 1'b0;

            if ((r_state == c_ST_CPURST) && (w_next_state == c_ST_CPURST)) begin
                r_rst_cnt <= r_rst_cnt + c_RC_W'(1);
            end else begin
                r_rst_cnt <= '0;
            end

            if ((w_next_state == c_ST_CPURST) && (r_state != c_ST_CPURST)) begin
                r_cycle_cnt <= 16'd0;
            end else if (w_cpu_en && (r_cycle_cnt != 16'hFFFF)) begin
                r_cycle_cnt <= r_cycle_cnt + 16'd1;
            end

            if ((r_state == c_ST_HALT) && w_accept) begin
                case (cmd_op)
                    c_OP_SET_ADDR: r_ptr <= cmd_data[ADDR_W-1:0];
                    c_OP_WRITE: begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_ptr;
                        r_imem_wdata <= cmd_data;
                        r_ptr        <= r_ptr + ADDR_W'(1);
                    end
                    c_OP_SET_BP: begin
                        r_bp_addr <= cmd_data[ADDR_W-1:0];
                        r_bp_en   <= cmd_data[7];
                    end
                    c_OP_RUN: begin
                        r_skip   <= 1'b1;
                        r_bp_hit <= 1'b0;
                    end
                    c_OP_STEP: r_bp_hit <= 1'b0;
                    default: ;
                endcase
            end

            if (r_state == c_ST_RUN) begin
                r_skip <= 1'b0;
                if (w_bp_match) begin
                    r_bp_hit <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign cpu_en     = w_cpu_en;
    assign cpu_rst    = r_cpu_rst;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign state      = r_state;
    assign bp_hit     = r_bp_hit;
    assign cycle_cnt  = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Brief    : Directed self-checking bench for cpu_run_ctrl with a PC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam logic [2:0] c_NOP = 3'd0, c_SET_ADDR = 3'd1, c_WRITE = 3'd2, c_RUN = 3'd3;
    localparam logic [2:0] c_STEP = 3'd4, c_HALT = 3'd5, c_SET_BP = 3'd6, c_RESET_CPU = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic [3:0]  pc;
    logic        cpu_halted;
    logic        cpu_en;
    logic        cpu_rst;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [7:0]  imem_wdata;
    logic [1:0]  state;
    logic        bp_hit;
    logic [15:0] cycle_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    cpu_run_ctrl #(.ADDR_W(4), .RST_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cpu_pc(pc), .cpu_halted(cpu_halted),
        .cpu_en(cpu_en), .cpu_rst(cpu_rst),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .state(state), .bp_hit(bp_hit), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // Simple core: PC advances on each enabled cycle, cleared by core reset
    always @(posedge clk) begin
        if (cpu_rst) pc <= 4'd0;
        else if (cpu_en) pc <= pc + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        #1;
        chk("send_ready", cmd_ready, 1);
        step_clk();
        cmd_valid = 1'b0;
        cmd_op    = c_NOP;
    endtask

    initial begin
        int  n;
        bit  en_at_bp;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = c_NOP; cmd_data = 8'd0; cpu_halted = 1'b0;
        pc = 4'd0;

        // Reset values
        repeat (3) step_clk();
        chk("rst_state", state, 3);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_bp_hit", bp_hit, 0);
        chk("rst_cnt", cycle_cnt, 0);
        rst = 1'b0;
        #1;
        chk("rel_c1_cpu_rst", cpu_rst, 1);
        step_clk();
        chk("rel_c2_cpu_rst", cpu_rst, 1);
        chk("rel_c2_state", state, 3);
        step_clk();
        chk("rel_c3_cpu_rst", cpu_rst, 0);
        chk("rel_c3_state", state, 0);
        chk("rel_c3_ready", cmd_ready, 1);
        chk("rel_c3_cnt", cycle_cnt, 0);

        // Load with address wrap
        send(c_SET_ADDR, 8'h0E);
        chk("load_idle_we", imem_we, 0);
        cmd_valid = 1'b1; cmd_op = c_WRITE; cmd_data = 8'hA1;
        step_clk();
        chk("wr0_we", imem_we, 1); chk("wr0_addr", imem_addr, 14); chk("wr0_data", imem_wdata, 8'hA1);
        cmd_data = 8'hB2;
        step_clk();
        chk("wr1_we", imem_we, 1); chk("wr1_addr", imem_addr, 15); chk("wr1_data", imem_wdata, 8'hB2);
        cmd_data = 8'hC3;
        step_clk();
        chk("wr2_we", imem_we, 1); chk("wr2_addr", imem_addr, 0); chk("wr2_data", imem_wdata, 8'hC3);
        cmd_valid = 1'b0; cmd_op = c_NOP;
        step_clk();
        chk("wr_done_we", imem_we, 0);

        // Run 10 cycles then halt
        send(c_RUN, 8'h00);
        chk("run_state", state, 1);
        for (int i = 0; i < 10; i++) begin
            chk("run_en", cpu_en, 1);
            step_clk();
        end
        cmd_valid = 1'b1; cmd_op = c_HALT;
        #1;
        chk("halt_same_cycle_en", cpu_en, 0);
        step_clk();
        cmd_valid = 1'b0; cmd_op = c_NOP;
        chk("halt_state", state, 0);
        chk("halt_cnt", cycle_cnt, 10);
        chk("halt_pc", pc, 10);

        // Core reset clears counter and PC
        send(c_RESET_CPU, 8'h00);
        chk("cpurst_state", state, 3);
        chk("cpurst_cnt", cycle_cnt, 0);
        step_clk();
        step_clk();
        chk("cpurst_done", state, 0);
        chk("cpurst_pc", pc, 0);

        // Breakpoint at PC 5
        send(c_SET_BP, 8'h85);
        send(c_RUN, 8'h00);
        n = 0; en_at_bp = 1'b0;
        while (state == 2'd1 && n < 40) begin
            if (pc == 4'd5 && cpu_en) en_at_bp = 1'b1;
            step_clk();
            n++;
        end
        chk("bp_bound", (n < 40), 1);
        chk("bp_pc", pc, 5);
        chk("bp_state", state, 0);
        chk("bp_hit", bp_hit, 1);
        chk("bp_no_en_at_bp", en_at_bp, 0);
        chk("bp_cnt", cycle_cnt, 5);
        send(c_RUN, 8'h00);
        chk("rerun_bp_hit_clr", bp_hit, 0);
        chk("rerun_en_at_bp", cpu_en, 1);
        step_clk();
        chk("rerun_pc", pc, 6);
        send(c_HALT, 8'h00);
        chk("rerun_halt_state", state, 0);
        chk("rerun_cnt", cycle_cnt, 6);

        // Three single steps
        for (int i = 0; i < 3; i++) begin
            send(c_STEP, 8'h00);
            chk("step_ready", cmd_ready, 0);
            chk("step_en", cpu_en, 1);
            step_clk();
            chk("step_back_halt", state, 0);
            chk("step_en_off", cpu_en, 0);
        end
        chk("step_cnt", cycle_cnt, 9);
        chk("step_pc", pc, 9);
        send(c_SET_BP, 8'h89);
        send(c_STEP, 8'h00);
        chk("step_at_bp_en", cpu_en, 1);
        step_clk();
        chk("step_at_bp_pc", pc, 10);
        chk("step_at_bp_cnt", cycle_cnt, 10);

        // Core HALT in RUN
        send(c_RUN, 8'h00);
        chk("chalt_run_en", cpu_en, 1);
        step_clk();
        cpu_halted = 1'b1;
        #1;
        chk("chalt_en", cpu_en, 0);
        step_clk();
        cpu_halted = 1'b0;
        chk("chalt_state", state, 0);
        chk("chalt_bp_hit", bp_hit, 0);
        chk("chalt_cnt", cycle_cnt, 11);

        // WRITE during RUN is ignored
        send(c_RUN, 8'h00);
        send(c_WRITE, 8'h55);
        chk("runwr_we", imem_we, 0);
        chk("runwr_state", state, 1);
        step_clk();
        chk("runwr_we2", imem_we, 0);

        // Reset during RUN
        rst = 1'b1;
        step_clk();
        chk("rstrun_state", state, 3);
        chk("rstrun_cpu_rst", cpu_rst, 1);
        chk("rstrun_en", cpu_en, 0);
        chk("rstrun_cnt", cycle_cnt, 0);
        rst = 1'b0;
        step_clk();
        step_clk();
        chk("rstrun_halt", state, 0);

        // Reset alongside a WRITE discards it
        cmd_valid = 1'b1; cmd_op = c_WRITE; cmd_data = 8'h77; rst = 1'b1;
        step_clk();
        chk("rstwr_we", imem_we, 0);
        chk("rstwr_state", state, 3);
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = c_NOP;
        step_clk();
        step_clk();
        chk("rstwr_halt", state, 0);

        // Saturation (breakpoint cleared by reset)
        send(c_RUN, 8'h00);
        for (int i = 0; i < 65534; i++) step_clk();
        chk("sat_fffe", cycle_cnt, 16'hFFFE);
        step_clk();
        chk("sat_ffff", cycle_cnt, 16'hFFFF);
        repeat (3) step_clk();
        chk("sat_hold", cycle_cnt, 16'hFFFF);
        chk("sat_state", state, 1);
        send(c_HALT, 8'h00);
        chk("sat_halt_cnt", cycle_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
